// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, register/latency
// constants and the NOP word used when IF/ID is flushed.
package pipeline_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [4:0]  REG_ZERO           = 5'd0;
  localparam int          MD_LATENCY_DEFAULT = 4;
  localparam logic [31:0] NOP_INSTR          = 32'h0;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall controller.
// master = stall controller, slave = pipeline datapath.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;
  logic             ex_jump;
  logic             ex_md_start;

  logic             pc_enable;
  logic             ifid_enable;
  logic             ifid_flush;
  logic             idex_enable;
  logic             idex_bubble;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, ex_jump, ex_md_start,
    output pc_enable, ifid_enable, ifid_flush, idex_enable, idex_bubble,
           md_busy, stall_cycles
  );

  modport slave (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, ex_jump, ex_md_start,
    input  pc_enable, ifid_enable, ifid_flush, idex_enable, idex_bubble,
           md_busy, stall_cycles
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the instruction in ID. $0 is hardwired and never hazards.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       hazard
);

  assign hazard = ex_mem_read && (ex_rt != REG_ZERO) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, EX branch/jump flushes and
// multi-cycle mult/div freezes, plus a saturating stall-cycle counter.
module hazard_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int CNT_W      = 16
) (
  input  logic                clock,
  input  logic                reset,
  hazard_stall_ctrl_if.master bus
);

  localparam logic [3:0] CNT_LOAD = 4'(MD_LATENCY - 1);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [CNT_W-1:0] stall_reg;
  logic             hazard;
  logic             redirect;
  logic             pc_en, ifid_en, idex_en, flush, bubble, busy;

  load_use_detect u_load_use_detect (
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rt  (bus.id_uses_rt),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .hazard      (hazard)
  );

  assign redirect = bus.ex_branch_taken | bus.ex_jump;

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    flush      = 1'b0;
    bubble     = 1'b0;
    busy       = 1'b0;
    state_next = state_reg;
    cnt_next   = cnt_reg;

    if (reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      flush      = 1'b1;
      bubble     = 1'b1;
      state_next = RUN;
      cnt_next   = 4'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (redirect) begin
            flush  = 1'b1;
            bubble = 1'b1;
          end else if (bus.ex_md_start) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            busy       = 1'b1;
            state_next = MD_WAIT;
            cnt_next   = CNT_LOAD;
          end else if (hazard) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            bubble  = 1'b1;
          end
        end
        MD_WAIT: begin
          if (cnt_reg != 4'd0) begin
            // EX is frozen, so nothing it reports can be acted on yet.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            busy     = 1'b1;
            cnt_next = cnt_reg - 4'd1;
          end else begin
            state_next = RUN;
            if (redirect) begin
              flush  = 1'b1;
              bubble = 1'b1;
            end else if (hazard) begin
              pc_en   = 1'b0;
              ifid_en = 1'b0;
              bubble  = 1'b1;
            end
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= 4'd0;
      stall_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (!pc_en && (stall_reg != {CNT_W{1'b1}}))
        stall_reg <= stall_reg + 1'b1;
    end
  end

  assign bus.pc_enable    = pc_en;
  assign bus.ifid_enable  = ifid_en;
  assign bus.idex_enable  = idex_en;
  assign bus.ifid_flush   = flush;
  assign bus.idex_bubble  = bubble;
  assign bus.md_busy      = busy;
  assign bus.stall_cycles = stall_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a 16-bit counter instance plus a
// 4-bit counter instance fed the same stimulus to exercise saturation.
module tb_hazard_stall_ctrl;
  import pipeline_pkg::*;

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  hazard_stall_ctrl_if #(.CNT_W(16)) bus ();
  hazard_stall_ctrl_if #(.CNT_W(4))  sat_bus ();

  hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut_sat (
    .clock (clock),
    .reset (reset),
    .bus   (sat_bus.master)
  );

  assign sat_bus.id_rs           = bus.id_rs;
  assign sat_bus.id_rt           = bus.id_rt;
  assign sat_bus.id_uses_rt      = bus.id_uses_rt;
  assign sat_bus.ex_mem_read     = bus.ex_mem_read;
  assign sat_bus.ex_rt           = bus.ex_rt;
  assign sat_bus.ex_branch_taken = bus.ex_branch_taken;
  assign sat_bus.ex_jump         = bus.ex_jump;
  assign sat_bus.ex_md_start     = bus.ex_md_start;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs           = 5'd0;
    bus.id_rt           = 5'd0;
    bus.id_uses_rt      = 1'b0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_rt           = 5'd0;
    bus.ex_branch_taken = 1'b0;
    bus.ex_jump         = 1'b0;
    bus.ex_md_start     = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    #12;
    $display("step reset_hold");
    check("rst_pc_enable",   32'(bus.pc_enable),    32'd0);
    check("rst_ifid_enable", 32'(bus.ifid_enable),  32'd0);
    check("rst_idex_enable", 32'(bus.idex_enable),  32'd0);
    check("rst_ifid_flush",  32'(bus.ifid_flush),   32'd1);
    check("rst_idex_bubble", 32'(bus.idex_bubble),  32'd1);
    check("rst_md_busy",     32'(bus.md_busy),      32'd0);

    reset = 1'b0;
    #1;
    $display("step reset_release");
    check("rel_pc_enable",   32'(bus.pc_enable),    32'd1);
    check("rel_idex_enable", 32'(bus.idex_enable),  32'd1);
    check("rel_ifid_flush",  32'(bus.ifid_flush),   32'd0);
    check("rel_stall_cycles", 32'(bus.stall_cycles), 32'd0);
    tick();

    // Load-use on rs.
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
    #1;
    $display("step load_use_rs");
    check("lu_pc_enable",   32'(bus.pc_enable),   32'd0);
    check("lu_ifid_enable", 32'(bus.ifid_enable), 32'd0);
    check("lu_idex_enable", 32'(bus.idex_enable), 32'd1);
    check("lu_idex_bubble", 32'(bus.idex_bubble), 32'd1);
    tick();
    clear_inputs();
    #1;
    $display("step load_use_done");
    check("lu_after_pc_enable", 32'(bus.pc_enable),    32'd1);
    check("lu_after_bubble",    32'(bus.idex_bubble),  32'd0);
    check("lu_stall_cycles",    32'(bus.stall_cycles), 32'd1);

    // $0 destination never stalls.
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
    #1;
    $display("step load_use_r0");
    check("r0_pc_enable",   32'(bus.pc_enable),   32'd1);
    check("r0_idex_bubble", 32'(bus.idex_bubble), 32'd0);
    tick();
    check("r0_stall_cycles", 32'(bus.stall_cycles), 32'd1);

    // Load-use on rt, then the same registers with rt not read.
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd7; bus.id_rs = 5'd1;
    bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
    #1;
    $display("step load_use_rt");
    check("rt_pc_enable", 32'(bus.pc_enable), 32'd0);
    tick();
    check("rt_stall_cycles", 32'(bus.stall_cycles), 32'd2);
    bus.id_uses_rt = 1'b0;
    #1;
    check("rt_unused_pc_enable", 32'(bus.pc_enable), 32'd1);
    clear_inputs();
    tick();

    // Multi-cycle op: frozen 4 cycles, released on the 5th.
    bus.ex_md_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      $display("step md_frozen cycle=%0d", i);
      check("md_pc_enable",   32'(bus.pc_enable),   32'd0);
      check("md_idex_enable", 32'(bus.idex_enable), 32'd0);
      check("md_busy",        32'(bus.md_busy),     32'd1);
      tick();
    end
    #1;
    $display("step md_release");
    check("md_rel_pc_enable",   32'(bus.pc_enable),    32'd1);
    check("md_rel_ifid_enable", 32'(bus.ifid_enable),  32'd1);
    check("md_rel_idex_enable", 32'(bus.idex_enable),  32'd1);
    check("md_rel_busy",        32'(bus.md_busy),      32'd0);
    check("md_stall_cycles",    32'(bus.stall_cycles), 32'd6);
    bus.ex_md_start = 1'b0;
    tick();
    check("md_after_pc_enable", 32'(bus.pc_enable), 32'd1);

    // Branch taken beats load-use.
    bus.ex_branch_taken = 1'b1; bus.ex_mem_read = 1'b1;
    bus.ex_rt = 5'd3; bus.id_rs = 5'd3;
    #1;
    $display("step branch_vs_load_use");
    check("br_ifid_flush",  32'(bus.ifid_flush),  32'd1);
    check("br_idex_bubble", 32'(bus.idex_bubble), 32'd1);
    check("br_pc_enable",   32'(bus.pc_enable),   32'd1);
    check("br_idex_enable", 32'(bus.idex_enable), 32'd1);
    tick();
    clear_inputs();
    check("br_stall_cycles", 32'(bus.stall_cycles), 32'd6);

    // Jump pulsed mid-freeze is ignored; release stays on schedule.
    bus.ex_md_start = 1'b1;
    tick();
    bus.ex_md_start = 1'b0;
    tick();
    bus.ex_jump = 1'b1;
    #1;
    $display("step md_jump_ignored");
    check("mdj_ifid_flush", 32'(bus.ifid_flush), 32'd0);
    check("mdj_pc_enable",  32'(bus.pc_enable),  32'd0);
    check("mdj_busy",       32'(bus.md_busy),    32'd1);
    tick();
    bus.ex_jump = 1'b0;
    #1;
    check("mdj_busy_cnt1", 32'(bus.md_busy), 32'd1);
    tick();
    $display("step md_jump_release");
    check("mdj_rel_busy",      32'(bus.md_busy),   32'd0);
    check("mdj_rel_pc_enable", 32'(bus.pc_enable), 32'd1);
    tick();
    check("mdj_stall_cycles", 32'(bus.stall_cycles), 32'd10);

    // Reset in the middle of a freeze aborts it.
    bus.ex_md_start = 1'b1;
    tick();
    bus.ex_md_start = 1'b0;
    tick();
    check("mdr_busy_before", 32'(bus.md_busy), 32'd1);
    reset = 1'b1;
    #1;
    $display("step reset_mid_md");
    check("mdr_rst_pc_enable",    32'(bus.pc_enable),    32'd0);
    check("mdr_rst_flush",        32'(bus.ifid_flush),   32'd1);
    check("mdr_rst_busy",         32'(bus.md_busy),      32'd0);
    check("mdr_rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("mdr_rel_busy",      32'(bus.md_busy),   32'd0);
    check("mdr_rel_pc_enable", 32'(bus.pc_enable), 32'd1);
    tick();
    check("mdr_run_pc_enable",    32'(bus.pc_enable),    32'd1);
    check("mdr_run_stall_cycles", 32'(bus.stall_cycles), 32'd0);

    // Saturation of the 4-bit counter under a held load-use stall.
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd9; bus.id_rs = 5'd9;
    for (int i = 0; i < 15; i++) tick();
    $display("step sat_reach");
    check("sat_at_max",  32'(sat_bus.stall_cycles), 32'hF);
    check("wide_at_15",  32'(bus.stall_cycles),     32'd15);
    tick();
    $display("step sat_hold");
    check("sat_stays_max", 32'(sat_bus.stall_cycles), 32'hF);
    check("wide_at_16",    32'(bus.stall_cycles),     32'd16);
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
